// File: rtl/count_uart_tx_pkg.sv
// Shared definitions for the count reporting UART.
// State codes and line levels used by the transmitter and its bench.
package count_uart_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/count_uart_tx_if.sv
// Signal bundle between the S-Machine count output and the UART reporter.
// The master side drives count; the slave side drives the serial line.
interface count_uart_tx_if;

    logic [7:0] count;
    logic       tx;
    logic       busy;
    logic       overrun;

    modport master (
        output count,
        input  tx,
        input  busy,
        input  overrun
    );

    modport slave (
        input  count,
        output tx,
        output busy,
        output overrun
    );

endinterface

// File: rtl/count_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while clear is high so every bit starts from a fresh count.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/count_uart_tx.sv
// Sends every new S-Machine count value as one UART 8N1 frame.
// One value is held while a frame is in flight; overwriting it pulses overrun.
module count_uart_tx
    import count_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    count_uart_tx_if.slave  bus
);

    if (CLKS_PER_BIT < 2) begin : g_bad_param
        $error("count_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    tx_state_e  state_q;
    logic [7:0] prev_q;
    logic [7:0] pend_data_q;
    logic [7:0] pend_data_d;
    logic       pend_v_q;
    logic       pend_v_d;
    logic [7:0] shift_q;
    logic [2:0] idx_q;
    logic       tx_q;
    logic       busy_q;
    logic       ovr_q;
    logic       ovr_d;

    logic       change;
    logic       consume;
    logic       clear;
    logic       bit_done;

    assign change  = (bus.count != prev_q);
    assign consume = (state_q == TX_IDLE) && pend_v_q;
    assign clear   = (state_q == TX_IDLE);

    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bit_done (bit_done)
    );

    // A change landing on the consume edge refills the slot without overrun.
    always_comb begin
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        ovr_d       = 1'b0;
        if (change) begin
            pend_v_d    = 1'b1;
            pend_data_d = bus.count;
            ovr_d       = pend_v_q && !consume;
        end else if (consume) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= TX_IDLE;
            prev_q      <= 8'h00;
            pend_data_q <= 8'h00;
            pend_v_q    <= 1'b0;
            shift_q     <= 8'h00;
            idx_q       <= 3'd0;
            tx_q        <= UART_IDLE;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            prev_q      <= bus.count;
            pend_data_q <= pend_data_d;
            pend_v_q    <= pend_v_d;
            ovr_q       <= ovr_d;
            unique case (state_q)
                TX_IDLE: begin
                    tx_q   <= UART_IDLE;
                    busy_q <= 1'b0;
                    if (pend_v_q) begin
                        shift_q <= pend_data_q;
                        state_q <= TX_START;
                        tx_q    <= UART_START;
                        busy_q  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        state_q <= TX_DATA;
                        idx_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        if (idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                            idx_q   <= 3'd0;
                            tx_q    <= UART_IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        state_q <= TX_IDLE;
                        tx_q    <= UART_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= UART_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = ovr_q;

endmodule
